// File: rtl/px_word_align.sv
// Training-pattern word aligner: sweeps the gearbox slip until the word matches
// TRAIN_PATTERN for MATCH_CNT cycles. Optional loss monitor: ALIGN_LOCK_MONITOR_EN.
module px_word_align #(
  parameter logic [11:0] TRAIN_PATTERN = 12'h03F,
  parameter int unsigned SETTLE_CYCLES = 32'd4,
  parameter int unsigned MATCH_CNT     = 32'd16,
  parameter int unsigned LOSS_CNT      = 32'd4
) (
  input  logic        px_clk,
  input  logic        px_reset_n,
  input  logic [11:0] din,
  input  logic        align_start,
  input  logic        train_active,
  output logic [3:0]  slip_num,
  output logic        busy,
  output logic        aligned,
  output logic        align_fail
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_NEXT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 32'd1);
  localparam logic [7:0] MATCH_LAST  = 8'(MATCH_CNT - 32'd1);
  localparam logic [7:0] LOSS_LAST   = 8'(LOSS_CNT - 32'd1);
  localparam logic [3:0] SLIP_MAX    = 4'd11;

  state_t      state_r, next_state_s;
  logic [3:0]  settle_cnt_r, settle_cnt_s;
  logic [7:0]  match_cnt_r, match_cnt_s;
  logic [3:0]  slip_num_r, slip_num_s;
  logic        busy_r, busy_s;
  logic        aligned_r, aligned_s;
  logic        align_fail_r, align_fail_s;
  logic        restart_s;
  logic        din_match_s;

`ifdef ALIGN_LOCK_MONITOR_EN
  logic [7:0]  loss_cnt_r, loss_cnt_s;
`else
  logic [8:0]  unused_s;
  assign unused_s = {train_active, LOSS_LAST};
`endif

  assign din_match_s = (din == TRAIN_PATTERN);

  assign slip_num   = slip_num_r;
  assign busy       = busy_r;
  assign aligned    = aligned_r;
  assign align_fail = align_fail_r;

  // Next-state and next-output decode for the search sequencer.
  always_comb begin
    next_state_s = state_r;
    settle_cnt_s = settle_cnt_r;
    match_cnt_s  = match_cnt_r;
    slip_num_s   = slip_num_r;
    busy_s       = busy_r;
    aligned_s    = aligned_r;
    align_fail_s = align_fail_r;
    restart_s    = 1'b0;
`ifdef ALIGN_LOCK_MONITOR_EN
    loss_cnt_s   = loss_cnt_r;
`endif

    case (state_r)
      ST_IDLE, ST_FAIL: begin
        if (align_start) begin
          restart_s = 1'b1;
        end else begin
          restart_s = 1'b0;
        end
      end

      ST_LOCKED: begin
`ifdef ALIGN_LOCK_MONITOR_EN
        // A start request and a loss trip collapse into the same single restart.
        if (align_start) begin
          restart_s = 1'b1;
        end else if (train_active && !din_match_s) begin
          if (loss_cnt_r >= LOSS_LAST) begin
            restart_s = 1'b1;
          end else begin
            loss_cnt_s = loss_cnt_r + 8'd1;
          end
        end else begin
          loss_cnt_s = 8'd0;
        end
`else
        if (align_start) begin
          restart_s = 1'b1;
        end else begin
          restart_s = 1'b0;
        end
`endif
      end

      ST_SETTLE: begin
        if (settle_cnt_r >= SETTLE_LAST) begin
          next_state_s = ST_CHECK;
          match_cnt_s  = 8'd0;
        end else begin
          settle_cnt_s = settle_cnt_r + 4'd1;
        end
      end

      ST_CHECK: begin
        if (din_match_s) begin
          match_cnt_s = (match_cnt_r == 8'hFF) ? 8'hFF : match_cnt_r + 8'd1;
          if (match_cnt_r >= MATCH_LAST) begin
            next_state_s = ST_LOCKED;
            aligned_s    = 1'b1;
            busy_s       = 1'b0;
          end else begin
            next_state_s = ST_CHECK;
          end
        end else begin
          next_state_s = ST_NEXT;
        end
      end

      ST_NEXT: begin
        if (slip_num_r < SLIP_MAX) begin
          slip_num_s   = slip_num_r + 4'd1;
          settle_cnt_s = 4'd0;
          next_state_s = ST_SETTLE;
        end else begin
          slip_num_s   = 4'd0;
          align_fail_s = 1'b1;
          busy_s       = 1'b0;
          next_state_s = ST_FAIL;
        end
      end

      default: begin
        next_state_s = ST_IDLE;
        settle_cnt_s = 4'd0;
        match_cnt_s  = 8'd0;
        slip_num_s   = 4'd0;
        busy_s       = 1'b0;
        aligned_s    = 1'b0;
        align_fail_s = 1'b0;
      end
    endcase

    if (restart_s) begin
      next_state_s = ST_SETTLE;
      settle_cnt_s = 4'd0;
      slip_num_s   = 4'd0;
      busy_s       = 1'b1;
      aligned_s    = 1'b0;
      align_fail_s = 1'b0;
`ifdef ALIGN_LOCK_MONITOR_EN
      loss_cnt_s   = 8'd0;
`endif
    end else begin
      next_state_s = next_state_s;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge px_clk or negedge px_reset_n) begin
    if (!px_reset_n) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= 4'd0;
      match_cnt_r  <= 8'd0;
      slip_num_r   <= 4'd0;
      busy_r       <= 1'b0;
      aligned_r    <= 1'b0;
      align_fail_r <= 1'b0;
`ifdef ALIGN_LOCK_MONITOR_EN
      loss_cnt_r   <= 8'd0;
`endif
    end else begin
      state_r      <= next_state_s;
      settle_cnt_r <= settle_cnt_s;
      match_cnt_r  <= match_cnt_s;
      slip_num_r   <= slip_num_s;
      busy_r       <= busy_s;
      aligned_r    <= aligned_s;
      align_fail_r <= align_fail_s;
`ifdef ALIGN_LOCK_MONITOR_EN
      loss_cnt_r   <= loss_cnt_s;
`endif
    end
  end

endmodule

// File: tb/tb_px_word_align.sv
// Bench for px_word_align: gearbox model feeding din from slip_num, a procedural
// search model predicting the outputs, directed timing checks and random runs.
module tb_px_word_align;

  localparam logic [11:0] PAT = 12'h03F;
  localparam int SETTLE = 4;
  localparam int MATCH  = 16;
  localparam int LOSS   = 4;

  logic        px_clk = 1'b0;
  logic        px_reset_n = 1'b0;
  logic        align_start = 1'b0;
  logic        train_active = 1'b0;
  logic [11:0] din;
  logic [3:0]  slip_num;
  logic        busy, aligned, align_fail;

  int  offset = 0;
  bit  noise  = 1'b0;
  bit  glitch = 1'b0;
  int  total  = 0;
  int  bad    = 0;

  logic [3:0] exp_slip = 4'd0;
  logic       exp_busy = 1'b0, exp_aligned = 1'b0, exp_fail = 1'b0;
  bit         m_abort = 1'b0, m_locked = 1'b0;
  int         m_loss = 0;

  px_word_align dut (
    .px_clk(px_clk), .px_reset_n(px_reset_n), .din(din),
    .align_start(align_start), .train_active(train_active),
    .slip_num(slip_num), .busy(busy), .aligned(aligned), .align_fail(align_fail)
  );

  always #5 px_clk = ~px_clk;

  // Gearbox: word arrives rotated left by (slip - offset) mod 12.
  function automatic logic [11:0] gear(input logic [3:0] s, input int off);
    int d;
    logic [23:0] w;
    d = (int'(s) + 12 - off) % 12;
    w = {PAT, PAT} << d;
    return w[23:12];
  endfunction

  assign din = noise ? 12'h555 : (glitch ? 12'hFFF : gear(slip_num, offset));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  task automatic tick();
    @(posedge px_clk or negedge px_reset_n);
    if (!px_reset_n) begin
      exp_slip = 4'd0; exp_busy = 1'b0; exp_aligned = 1'b0; exp_fail = 1'b0;
      m_locked = 1'b0; m_loss = 0; m_abort = 1'b1;
    end
  endtask

  task automatic search();
    int n;
    exp_busy = 1'b1; exp_aligned = 1'b0; exp_fail = 1'b0; exp_slip = 4'd0;
    m_locked = 1'b0; m_loss = 0;
    for (int k = 0; k < 12; k++) begin
      repeat (SETTLE) begin
        tick();
        if (m_abort) return;
      end
      n = 0;
      forever begin
        tick();
        if (m_abort) return;
        if (din != PAT) break;
        n++;
        if (n >= MATCH) begin
          exp_aligned = 1'b1; exp_busy = 1'b0; m_locked = 1'b1;
          return;
        end
      end
      tick();
      if (m_abort) return;
      if (k < 11) begin
        exp_slip = 4'(k + 1);
      end else begin
        exp_slip = 4'd0; exp_fail = 1'b1; exp_busy = 1'b0;
        return;
      end
    end
  endtask

  initial begin : model
    bit go;
    forever begin
      tick();
      if (!m_abort && px_reset_n) begin
        go = align_start;
`ifdef ALIGN_LOCK_MONITOR_EN
        if (!go && m_locked) begin
          if (train_active && din != PAT) begin
            m_loss++;
            if (m_loss >= LOSS) go = 1'b1;
          end else begin
            m_loss = 0;
          end
        end
`endif
        if (go) search();
      end
      m_abort = 1'b0;
    end
  end

  // Compare process: outputs against the model every cycle.
  always @(negedge px_clk) begin
    check("slip_num", slip_num, exp_slip);
    check("busy", busy, exp_busy);
    check("aligned", aligned, exp_aligned);
    check("align_fail", align_fail, exp_fail);
    check("slip_range", slip_num <= 4'd11, 1'b1);
  end

  // ---------------- stimulus ----------------
  task automatic pulse();
    @(negedge px_clk) align_start = 1'b1;
    @(negedge px_clk) align_start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int i;
    i = 0;
    while (!(aligned || align_fail) && i < max) begin
      @(negedge px_clk);
      i++;
    end
    check("done_timeout", aligned || align_fail, 1'b1);
  endtask

  task automatic wait_slip(input logic [3:0] v);
    int i;
    i = 0;
    while (slip_num != v && i < 200) begin
      @(negedge px_clk);
      i++;
    end
    check("slip_wait", slip_num, v);
  endtask

  initial begin : drive
    int mode;
    repeat (3) @(negedge px_clk);
    px_reset_n = 1'b1;
    @(negedge px_clk);
    check("rst_slip", slip_num, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_aligned", aligned, 1'b0);
    check("rst_fail", align_fail, 1'b0);

    // Offset 0: lock after E0+20
    offset = 0;
    pulse();
    check("busy_after_e0", busy, 1'b1);
    repeat (19) @(negedge px_clk);
    check("lock0_e19", aligned, 1'b0);
    @(negedge px_clk);
    check("lock0_e20", aligned, 1'b1);
    check("lock0_slip", slip_num, 4'd0);
    check("lock0_busy", busy, 1'b0);
    check("lock0_fail", align_fail, 1'b0);

    // Offset 7
    offset = 7;
    pulse();
    wait_done(200);
    check("lock7_slip", slip_num, 4'd7);
    check("lock7_aligned", aligned, 1'b1);

    // Constant 12'h555: full sweep fails at E0+72
    noise = 1'b1;
    pulse();
    repeat (71) @(negedge px_clk);
    check("fail_e71", align_fail, 1'b0);
    @(negedge px_clk);
    check("fail_e72", align_fail, 1'b1);
    check("fail_slip", slip_num, 4'd0);
    check("fail_aligned", aligned, 1'b0);
    check("fail_busy", busy, 1'b0);
    noise = 1'b0;

    // Offset 3, 10th match corrupted; extra start while busy is ignored
    offset = 3;
    pulse();
    wait_slip(4'd3);
    repeat (13) @(negedge px_clk);
    glitch = 1'b1;
    @(negedge px_clk);
    glitch = 1'b0;
    pulse();
    wait_done(200);
    check("corrupt_fail", align_fail, 1'b1);
    check("corrupt_aligned", aligned, 1'b0);
    pulse();
    wait_done(200);
    check("relock3_aligned", aligned, 1'b1);
    check("relock3_slip", slip_num, 4'd3);

    // Reset during CHECK at slip 5
    offset = 9;
    pulse();
    wait_slip(4'd5);
    repeat (SETTLE) @(negedge px_clk);
    #2 px_reset_n = 1'b0;
    #1;
    check("midrst_slip", slip_num, 4'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_aligned", aligned, 1'b0);
    check("midrst_fail", align_fail, 1'b0);
    repeat (2) @(negedge px_clk);
    px_reset_n = 1'b1;
    @(negedge px_clk);
    check("postrst_slip", slip_num, 4'd0);
    check("postrst_busy", busy, 1'b0);
    pulse();
    wait_done(200);
    check("postrst_lock9", slip_num, 4'd9);

`ifdef ALIGN_LOCK_MONITOR_EN
    offset = 2;
    pulse();
    wait_done(200);
    check("mon_lock2", slip_num, 4'd2);
    train_active = 1'b1;
    glitch = 1'b1;
    repeat (LOSS) @(negedge px_clk);
    glitch = 1'b0;
    check("mon_loss_aligned", aligned, 1'b0);
    check("mon_loss_busy", busy, 1'b1);
    wait_done(200);
    check("mon_relock", aligned, 1'b1);
    check("mon_relock_slip", slip_num, 4'd2);
    train_active = 1'b0;
    glitch = 1'b1;
    repeat (LOSS) @(negedge px_clk);
    glitch = 1'b0;
    check("mon_inactive_hold", aligned, 1'b1);
    repeat (4) @(negedge px_clk);
    check("mon_inactive_hold2", aligned, 1'b1);
`endif

    // Randomized runs
    for (int it = 0; it < 40; it++) begin
      offset = $urandom_range(0, 11);
      mode = $urandom_range(0, 3);
      train_active = 1'($urandom_range(0, 1));
      noise = (mode == 1);
      pulse();
      for (int c = 0; c < 150; c++) begin
        @(negedge px_clk);
        glitch = (mode >= 2) && ($urandom_range(0, 19) == 0);
        align_start = (mode == 3) && ($urandom_range(0, 39) == 0);
      end
      @(negedge px_clk);
      glitch = 1'b0;
      align_start = 1'b0;
      noise = 1'b0;
      wait_done(400);
    end

    repeat (2) @(negedge px_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
